// File: rtl/opp_frame_decoder.sv
// opp_frame_decoder: decodes RMII opponent-position frames into registered fields.
//   Ports: eth_clk (50 MHz RMII ref clock), eth_rst_n (async active-low reset),
//          eth_crsdv / eth_rxd (RMII carrier-sense/data-valid and receive dibit),
//          opp_valid (good-frame pulse), opp_x/opp_y/opp_dir/opp_game/opp_reset (decoded fields),
//          frame_err (rejected-frame pulse), good_count (wrapping good-frame count).
//   Macro OPP_FRAME_CHECKSUM_EN adds a 7th XOR checksum byte after the 6-byte payload.
module opp_frame_decoder #(
    parameter int         MIN_PREAMBLE = 8,
    parameter logic [3:0] MAGIC        = 4'hA
) (
    input  logic        eth_clk,
    input  logic        eth_rst_n,
    input  logic        eth_crsdv,
    input  logic [1:0]  eth_rxd,
    output logic        opp_valid,
    output logic [10:0] opp_x,
    output logic [10:0] opp_y,
    output logic [8:0]  opp_dir,
    output logic [2:0]  opp_game,
    output logic        opp_reset,
    output logic        frame_err,
    output logic [7:0]  good_count
);
`ifdef OPP_FRAME_CHECKSUM_EN
    localparam int NB = 56;
`else
    localparam int NB = 48;
`endif
    localparam int ND = NB / 2;
    typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, CHECK, DRAIN} state_t;
    state_t r_state, w_next;
    logic [1:0] r_sync;
    logic w_rst_n;
    logic [5:0] r_cnt, w_cnt;
    logic [NB-3:0] r_shift;
    logic [NB-1:0] w_raw;
    logic [47:0] w_pay;
    logic w_good, w_last, w_drop, w_unused;
    // Assertion is immediate; release is held off two clocks so every flop leaves reset cleanly.
    always_ff @(posedge eth_clk or negedge eth_rst_n)
        if (!eth_rst_n) r_sync <= 2'b00;
        else r_sync <= {r_sync[0], 1'b1};
    assign w_rst_n = r_sync[1];
    // Dibit k of the frame lands at w_raw[2k+1:2k], so byte n sits at w_raw[8n+7:8n].
    assign w_raw = {eth_rxd, r_shift};
    // The first received byte is the most significant payload byte.
    always_comb begin
        w_pay = '0;
        for (int i = 0; i < 6; i++) w_pay[47 - 8*i -: 8] = w_raw[8*i +: 8];
    end
`ifdef OPP_FRAME_CHECKSUM_EN
    assign w_good = w_pay[47:44] == MAGIC &&
                    w_raw[55:48] == (w_pay[47:40] ^ w_pay[39:32] ^ w_pay[31:24] ^ w_pay[23:16] ^ w_pay[15:8] ^ w_pay[7:0]);
`else
    assign w_good = w_pay[47:44] == MAGIC;
`endif
    assign w_unused = ^{w_pay[32], w_pay[20], w_pay[10:8], w_pay[4], w_pay[2:0]};
    // The verdict is taken on the edge that samples the final dibit, so the pulse shows one cycle later.
    assign w_last = r_state == PAYLOAD && eth_crsdv && int'(r_cnt) == ND - 1;
    assign w_drop = r_state == PAYLOAD && !eth_crsdv;
    always_ff @(posedge eth_clk or negedge w_rst_n)
        if (!w_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
        end
    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        case (r_state)
            IDLE:
                if (eth_crsdv) begin
                    w_next = eth_rxd == 2'b01 ? PREAMBLE : DRAIN;
                    w_cnt  = 6'd1;
                end
            PREAMBLE:
                if (!eth_crsdv) w_next = IDLE;
                else if (eth_rxd == 2'b01) w_cnt = r_cnt == 6'd63 ? r_cnt : r_cnt + 6'd1;
                else if (eth_rxd == 2'b11 && int'(r_cnt) >= MIN_PREAMBLE) begin
                    w_next = PAYLOAD;
                    w_cnt  = '0;
                end else w_next = DRAIN;
            PAYLOAD:
                if (!eth_crsdv) w_next = IDLE;
                else begin
                    w_cnt = r_cnt + 6'd1;
                    if (int'(r_cnt) == ND - 1) w_next = CHECK;
                end
            // Carrier already low here means the inter-frame gap has started, so skip straight
            // past DRAIN; otherwise a single-cycle gap would swallow the next frame.
            CHECK: w_next = eth_crsdv ? DRAIN : IDLE;
            DRAIN: if (!eth_crsdv) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge eth_clk or negedge w_rst_n)
        if (!w_rst_n) begin
            r_shift    <= '0;
            opp_valid  <= 1'b0;
            frame_err  <= 1'b0;
            opp_x      <= '0;
            opp_y      <= '0;
            opp_dir    <= '0;
            opp_game   <= '0;
            opp_reset  <= 1'b0;
            good_count <= '0;
        end else begin
            opp_valid <= w_last && w_good;
            frame_err <= (w_last && !w_good) || w_drop;
            if (r_state == PAYLOAD && eth_crsdv) r_shift <= w_raw[NB-1:2];
            if (w_last && w_good) begin
                opp_x      <= w_pay[43:33];
                opp_y      <= w_pay[31:21];
                opp_dir    <= w_pay[19:11];
                opp_game   <= w_pay[7:5];
                opp_reset  <= w_pay[3];
                good_count <= good_count + 8'd1;
            end
        end
endmodule

// File: tb/tb_opp_frame_decoder.sv
// tb_opp_frame_decoder: randomized frame stimulus checked every cycle against a frame-level model.
module tb_opp_frame_decoder;
    logic        eth_clk = 1'b0, eth_rst_n = 1'b1, eth_crsdv = 1'b0;
    logic [1:0]  eth_rxd = 2'b00;
    logic        opp_valid, frame_err, opp_reset;
    logic [10:0] opp_x, opp_y;
    logic [8:0]  opp_dir;
    logic [2:0]  opp_game;
    logic [7:0]  good_count;
`ifdef OPP_FRAME_CHECKSUM_EN
    localparam int NBY = 7;
`else
    localparam int NBY = 6;
`endif
    localparam int MIN_PRE = 8;
    int total = 0, bad = 0, cyc = 0, p_cyc = -1, fr_cyc = -1;
    int n_valid = 0, n_err = 0, last_v = -1, last_e = -1;
    logic        p_good = 1'b0, p_rst = 1'b0, m_rst = 1'b0;
    logic [10:0] p_x = '0, p_y = '0, m_x = '0, m_y = '0;
    logic [8:0]  p_dir = '0, m_dir = '0;
    logic [2:0]  p_game = '0, m_game = '0;
    logic [7:0]  m_cnt = '0;

    opp_frame_decoder dut (
        .eth_clk(eth_clk), .eth_rst_n(eth_rst_n), .eth_crsdv(eth_crsdv), .eth_rxd(eth_rxd),
        .opp_valid(opp_valid), .opp_x(opp_x), .opp_y(opp_y), .opp_dir(opp_dir),
        .opp_game(opp_game), .opp_reset(opp_reset), .frame_err(frame_err), .good_count(good_count)
    );

    always #5 eth_clk = ~eth_clk;
    always @(posedge eth_clk) cyc <= cyc + 1;

    function automatic logic [63:0] outs();
        return {19'd0, opp_valid, frame_err, opp_x, opp_y, opp_dir, opp_game, opp_reset, good_count};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge eth_clk) begin
        #1;
        if (cyc == p_cyc && p_good) begin
            m_x = p_x; m_y = p_y; m_dir = p_dir; m_game = p_game; m_rst = p_rst;
            m_cnt = m_cnt + 8'd1;
        end
        if (opp_valid) begin n_valid++; last_v = cyc; end
        if (frame_err) begin n_err++; last_e = cyc; end
        chk("cycle", outs(), {19'd0, cyc == p_cyc && p_good, cyc == p_cyc && !p_good,
                              m_x, m_y, m_dir, m_game, m_rst, m_cnt});
    end

    task automatic drive(input logic c, input logic [1:0] d);
        @(negedge eth_clk);
        eth_crsdv = c;
        eth_rxd   = d;
    endtask

    task automatic reset_pulse();
        #1 eth_rst_n = 1'b0;
        m_x = '0; m_y = '0; m_dir = '0; m_game = '0; m_rst = 1'b0; m_cnt = '0; p_cyc = -1;
        #1 chk("rst_zero", outs(), 64'd0);
        drive(1'b0, 2'b00);
        eth_rst_n = 1'b1;
        repeat (3) drive(1'b0, 2'b00);
    endtask

    // start/corrupt < 0 means absent; otherwise the dibit sent before / after the preamble.
    task automatic send(input int npre, input int start, input int corrupt, input logic [3:0] mg,
                        input logic [10:0] x, input logic [10:0] y, input logic [8:0] dir,
                        input logic [2:0] gm, input logic rs, input int bad_cks,
                        input int drop_at, input int rst_at, input int gap);
        logic [47:0] pay;
        logic [7:0]  by [7];
        logic        ok, good;
        pay = {mg, x, 1'($urandom), y, 1'($urandom), dir, 3'($urandom), gm, 1'($urandom), rs, 3'($urandom)};
        by[6] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            by[i] = pay[47 - 8*i -: 8];
            by[6] = by[6] ^ by[i];
        end
        if (bad_cks != 0) by[6] = by[6] ^ 8'h01;
        ok   = start < 0 && corrupt < 0 && npre >= MIN_PRE;
        good = mg == 4'hA && (NBY == 6 || bad_cks == 0);
        if (start >= 0) drive(1'b1, 2'(start));
        for (int i = 0; i < npre; i++) drive(1'b1, 2'b01);
        if (corrupt >= 0) drive(1'b1, 2'(corrupt));
        drive(1'b1, 2'b11);
        for (int k = 0; k < 4*NBY; k++) begin
            if (k == drop_at) begin
                drive(1'b0, 2'b00);
                fr_cyc = cyc + 1;
                if (ok) begin p_cyc = cyc + 1; p_good = 1'b0; end
                break;
            end
            drive(1'b1, by[k/4][2*(k%4) +: 2]);
            if (k == rst_at) begin
                reset_pulse();
                return;
            end
            if (k == 4*NBY - 1) begin
                fr_cyc = cyc + 1;
                if (ok) begin
                    p_cyc = cyc + 1; p_good = good;
                    p_x = x; p_y = y; p_dir = dir; p_game = gm; p_rst = rs;
                end
            end
        end
        repeat (gap) drive(1'b0, 2'b00);
    endtask

    initial begin
        int m, s, v0, e0;
        #1 eth_rst_n = 1'b0;
        #1 chk("rst_noclk", outs(), 64'd0);
        repeat (2) drive(1'b0, 2'b00);
        eth_rst_n = 1'b1;
        repeat (3) drive(1'b0, 2'b00);
        chk("reset_state", outs(), 64'd0);
        // Reference good frame with hand-computed field values.
        send(31, -1, -1, 4'hA, 11'd191, 11'd100, 9'd270, 3'd1, 1'b0, 0, -1, -1, 2);
        chk("good_lat", 64'(last_v), 64'(fr_cyc));
        chk("good_fields", {opp_x, opp_y, opp_dir, opp_game, opp_reset}, {11'd191, 11'd100, 9'd270, 3'd1, 1'b0});
        chk("good_cnt", good_count, 8'd1);
        // Preamble one short of the minimum: silently dropped.
        v0 = n_valid; e0 = n_err;
        send(MIN_PRE - 1, -1, -1, 4'hA, 11'd7, 11'd7, 9'd7, 3'd7, 1'b1, 0, -1, -1, 1);
        chk("short_pre", {32'(n_valid), 32'(n_err)}, {32'(v0), 32'(e0)});
        chk("short_keep", opp_x, 11'd191);
        // Preamble exactly at the minimum: accepted.
        send(MIN_PRE, -1, -1, 4'hA, 11'd5, 11'd2047, 9'd511, 3'd7, 1'b1, 0, -1, -1, 1);
        chk("min_pre", {opp_x, opp_y, opp_dir, opp_game, opp_reset, good_count}, {11'd5, 11'd2047, 9'd511, 3'd7, 1'b1, 8'd2});
        // Carrier drop after 10 payload dibits.
        e0 = n_err;
        send(12, -1, -1, 4'hA, 11'd9, 11'd9, 9'd9, 3'd0, 1'b0, 0, 10, -1, 1);
        chk("drop_err", 64'(n_err), 64'(e0 + 1));
        chk("drop_lat", 64'(last_e), 64'(fr_cyc));
        chk("drop_keep", {opp_x, good_count}, {11'd5, 8'd2});
        send(9, -1, -1, 4'hA, 11'd1000, 11'd3, 9'd4, 3'd2, 1'b0, 0, -1, -1, 1);
        chk("after_drop", {opp_x, good_count}, {11'd1000, 8'd3});
        // Wrong magic.
        e0 = n_err;
        send(10, -1, -1, 4'h5, 11'd1, 11'd1, 9'd1, 3'd1, 1'b1, 0, -1, -1, 1);
        chk("bad_magic", {32'(n_err), 24'd0, good_count}, {32'(e0 + 1), 24'd0, 8'd3});
        // Checksum off by one bit: only an error when the checksum byte exists.
        e0 = n_err;
        send(10, -1, -1, 4'hA, 11'd77, 11'd1, 9'd1, 3'd1, 1'b1, 1, -1, -1, 1);
        chk("bad_cks", {32'(n_err), 24'd0, good_count},
            {32'(e0 + (NBY == 7 ? 1 : 0)), 24'd0, NBY == 7 ? 8'd3 : 8'd4});
        // Reset asserted while payload dibit 12 is on the wire.
        e0 = n_err;
        send(10, -1, -1, 4'hA, 11'd50, 11'd50, 9'd50, 3'd5, 1'b1, 0, -1, 12, 1);
        chk("rst_noerr", 64'(n_err), 64'(e0));
        send(8, -1, -1, 4'hA, 11'd123, 11'd456, 9'd78, 3'd3, 1'b1, 0, -1, -1, 1);
        chk("rst_next", {opp_x, opp_y, good_count}, {11'd123, 11'd456, 8'd1});
        // 255 more back-to-back frames: 256 since reset, so the count wraps to zero.
        v0 = n_valid;
        for (int f = 0; f < 255; f++)
            send(MIN_PRE, -1, -1, 4'hA, 11'($urandom), 11'($urandom), 9'($urandom), 3'($urandom), 1'($urandom), 0, -1, -1, 1);
        chk("wrap", {32'(n_valid - v0), 24'd0, good_count}, {32'd255, 24'd0, 8'd0});
        // Random mix of good, short, corrupted, garbage, bad and truncated frames.
        for (int f = 0; f < 150; f++) begin
            m = $urandom_range(0, 9);
            s = $urandom_range(0, 2);
            send(m == 0 ? int'($urandom_range(1, MIN_PRE - 1)) : int'($urandom_range(MIN_PRE, 70)),
                 m == 2 ? (s == 1 ? 3 : s) : -1,
                 m == 1 ? 2 * int'($urandom_range(0, 1)) : -1,
                 $urandom_range(0, 4) == 0 ? 4'($urandom) : 4'hA,
                 11'($urandom), 11'($urandom), 9'($urandom), 3'($urandom), 1'($urandom),
                 $urandom_range(0, 4) == 0 ? 1 : 0,
                 $urandom_range(0, 6) == 0 ? int'($urandom_range(0, 4*NBY - 1)) : -1,
                 -1, $urandom_range(1, 3));
        end
        repeat (3) drive(1'b0, 2'b00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
